// File: rtl/chess_timer_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chess_timer_bank                                                           |
// | Multi-player countdown bank: one timer per player, turn rotation,         |
// | Fischer increment and sticky flag fall without wrap-around.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module chess_timer_bank #(
    parameter  int NUM_PLAYERS = 2,
    parameter  int TIME_W      = 8,
    parameter  int INIT_TIME   = 60,
    parameter  int INCREMENT   = 0,
    parameter  int TICK_DIV    = 1,
    localparam int ACT_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                          clk_four,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          turn_end,
    output logic [ACT_W-1:0]              active,
    output logic [NUM_PLAYERS*TIME_W-1:0] times,
    output logic [NUM_PLAYERS-1:0]        zero,
    output logic                          running,
    output logic                          game_over
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_FLAGGED = 2'd3;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [ACT_W-1:0]  ACT_LAST = ACT_W'(NUM_PLAYERS - 1);
    localparam logic [ACT_W-1:0]  ACT_ONE  = ACT_W'(1);
    localparam logic [TIME_W-1:0] INIT_VAL = TIME_W'(INIT_TIME);
    localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);
    localparam logic [TIME_W:0]   INC_EXT  = (TIME_W + 1)'(INCREMENT);

    logic [1:0]        state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [ACT_W-1:0]  active_q, active_d;
    logic [NUM_PLAYERS-1:0] zero_q, zero_d;
    logic [TIME_W-1:0] times_q [NUM_PLAYERS];
    logic [TIME_W-1:0] times_d [NUM_PLAYERS];

    logic              tick;
    logic              flag;
    logic              turn_acc;
    logic [TIME_W-1:0] cur_time;
    logic [TIME_W-1:0] dec_time;
    logic [TIME_W:0]   inc_sum;

    always_comb begin
        tick     = (state_q == S_RUN) && (pre_q == PRE_LAST);
        cur_time = times_q[active_q];
        // A counter already at zero flags on the next tick instead of wrapping.
        flag     = tick && (cur_time == '0);
        turn_acc = (state_q == S_RUN) && turn_end && !flag;
        dec_time = (tick && (cur_time != '0)) ? (cur_time - TIME_ONE) : cur_time;
        inc_sum  = {1'b0, dec_time} + INC_EXT;
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        active_d = active_q;
        zero_d   = zero_q;
        times_d  = times_q;
        case (state_q)
            S_IDLE, S_PAUSED: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                pre_d = tick ? '0 : (pre_q + PRE_ONE);
                if (flag) begin
                    zero_d[active_q] = 1'b1;
                    state_d          = S_FLAGGED;
                end else begin
                    times_d[active_q] = dec_time;
                    if (turn_acc) begin
                        // The new mover starts a fresh time unit.
                        times_d[active_q] = inc_sum[TIME_W] ? '1 : inc_sum[TIME_W-1:0];
                        active_d          = (active_q == ACT_LAST) ? '0 : (active_q + ACT_ONE);
                        pre_d             = '0;
                    end
                    if (!start) state_d = S_PAUSED;
                end
            end
            S_FLAGGED: begin
                state_d = S_FLAGGED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_four) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            active_q <= '0;
            zero_q   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) times_q[i] <= INIT_VAL;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            active_q <= active_d;
            zero_q   <= zero_d;
            for (int i = 0; i < NUM_PLAYERS; i++) times_q[i] <= times_d[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
            assign times[g*TIME_W +: TIME_W] = times_q[g];
        end
    endgenerate

    assign active    = active_q;
    assign zero      = zero_q;
    assign running   = (state_q == S_RUN);
    assign game_over = (state_q == S_FLAGGED);

endmodule
`default_nettype wire

// File: tb/tb_chess_timer_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_chess_timer_bank                                                        |
// | Five differently parameterised banks driven in lock-step, checked         |
// | against a behavioural model of the timer rules. Rev 1.0                   |
// +----------------------------------------------------------------------------+
module tb_chess_timer_bank;

    localparam int NDUT = 5;
    localparam int NP   [NDUT] = '{2, 2, 2, 3, 2};
    localparam int INIT [NDUT] = '{60, 60, 2, 60, 254};
    localparam int INC  [NDUT] = '{0, 3, 0, 0, 5};
    localparam int DIV  [NDUT] = '{1, 1, 1, 4, 1};

    logic clk_four = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic turn_end = 1'b0;

    logic [15:0] times0, times1, times2, times4;
    logic [23:0] times3;
    logic [0:0]  active0, active1, active2, active4;
    logic [1:0]  active3;
    logic [1:0]  zero0, zero1, zero2, zero4;
    logic [2:0]  zero3;
    logic [NDUT-1:0] run_v, go_v;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: remaining time, flag bits, mover, mode (0 idle,1 run,2 paused,3 flagged)
    int m_time [NDUT][3];
    bit m_zero [NDUT][3];
    int m_act  [NDUT];
    int m_mode [NDUT];
    int m_sub  [NDUT];

    always #5 clk_four = ~clk_four;

    chess_timer_bank u0 (.clk_four(clk_four), .reset(reset), .start(start), .turn_end(turn_end),
        .active(active0), .times(times0), .zero(zero0), .running(run_v[0]), .game_over(go_v[0]));
    chess_timer_bank #(.INCREMENT(3)) u1 (.clk_four(clk_four), .reset(reset), .start(start),
        .turn_end(turn_end), .active(active1), .times(times1), .zero(zero1), .running(run_v[1]),
        .game_over(go_v[1]));
    chess_timer_bank #(.INIT_TIME(2)) u2 (.clk_four(clk_four), .reset(reset), .start(start),
        .turn_end(turn_end), .active(active2), .times(times2), .zero(zero2), .running(run_v[2]),
        .game_over(go_v[2]));
    chess_timer_bank #(.NUM_PLAYERS(3), .TICK_DIV(4)) u3 (.clk_four(clk_four), .reset(reset),
        .start(start), .turn_end(turn_end), .active(active3), .times(times3), .zero(zero3),
        .running(run_v[3]), .game_over(go_v[3]));
    chess_timer_bank #(.INIT_TIME(254), .INCREMENT(5)) u4 (.clk_four(clk_four), .reset(reset),
        .start(start), .turn_end(turn_end), .active(active4), .times(times4), .zero(zero4),
        .running(run_v[4]), .game_over(go_v[4]));

    function automatic logic [7:0] dut_time(input int k, input int p);
        case (k)
            0: return times0[p*8 +: 8];
            1: return times1[p*8 +: 8];
            2: return times2[p*8 +: 8];
            3: return times3[p*8 +: 8];
            default: return times4[p*8 +: 8];
        endcase
    endfunction

    function automatic logic [1:0] dut_active(input int k);
        case (k)
            0: return {1'b0, active0};
            1: return {1'b0, active1};
            2: return {1'b0, active2};
            3: return active3;
            default: return {1'b0, active4};
        endcase
    endfunction

    function automatic logic dut_zero(input int k, input int p);
        case (k)
            0: return zero0[p];
            1: return zero1[p];
            2: return zero2[p];
            3: return zero3[p];
            default: return zero4[p];
        endcase
    endfunction

    function automatic void model_step(input int k, input bit r, input bit s, input bit t);
        bit unit_done;
        bit flagged;
        if (r) begin
            for (int p = 0; p < 3; p++) begin
                m_time[k][p] = INIT[k];
                m_zero[k][p] = 1'b0;
            end
            m_act[k]  = 0;
            m_mode[k] = 0;
            m_sub[k]  = 0;
            return;
        end
        if (m_mode[k] == 0 || m_mode[k] == 2) begin
            if (s) m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
            m_sub[k]++;
            unit_done = (m_sub[k] == DIV[k]);
            if (unit_done) m_sub[k] = 0;
            flagged = 1'b0;
            if (unit_done) begin
                if (m_time[k][m_act[k]] > 0) m_time[k][m_act[k]] -= 1;
                else begin
                    m_zero[k][m_act[k]] = 1'b1;
                    flagged = 1'b1;
                end
            end
            if (flagged) m_mode[k] = 3;
            else begin
                if (t) begin
                    m_time[k][m_act[k]] += INC[k];
                    if (m_time[k][m_act[k]] > 255) m_time[k][m_act[k]] = 255;
                    m_act[k] = (m_act[k] + 1) % NP[k];
                    m_sub[k] = 0;
                end
                if (!s) m_mode[k] = 2;
            end
        end
    endfunction

    task automatic cycle(input bit r, input bit s, input bit t);
        reset = r;
        start = s;
        turn_end = t;
        @(posedge clk_four);
        for (int k = 0; k < NDUT; k++) model_step(k, r, s, t);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < NDUT; k++) begin
            n_tests++;
            if (dut_active(k) !== 2'd0 || run_v[k] !== 1'b0 || go_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl dut%0d: active=%0d running=%b game_over=%b, want 0/0/0",
                         k, dut_active(k), run_v[k], go_v[k]);
            end
            for (int p = 0; p < NP[k]; p++) begin
                n_tests++;
                if (dut_time(k, p) !== 8'(INIT[k]) || dut_zero(k, p) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_time dut%0d p%0d: time=%0d zero=%b, want %0d/0",
                             k, p, dut_time(k, p), dut_zero(k, p), INIT[k]);
                end
            end
        end
    endtask

    task automatic test_countdown;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run(5);
        n_tests++;
        if (dut_time(0, 0) !== 8'd55 || dut_time(0, 1) !== 8'd60) begin
            n_fail++;
            $display("FAIL countdown_times: got %0d/%0d, want 55/60", dut_time(0, 0), dut_time(0, 1));
        end
        n_tests++;
        if (dut_active(0) !== 2'd0 || run_v[0] !== 1'b1 || zero0 !== 2'b00) begin
            n_fail++;
            $display("FAIL countdown_ctrl: active=%0d running=%b zero=%b, want 0/1/00",
                     dut_active(0), run_v[0], zero0);
        end
    endtask

    task automatic test_increment;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run(10);
        cycle(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (dut_time(1, 0) !== 8'd52 || dut_active(1) !== 2'd1) begin
            n_fail++;
            $display("FAIL increment_turn: time0=%0d active=%0d, want 52/1", dut_time(1, 0), dut_active(1));
        end
        n_tests++;
        if (dut_time(0, 0) !== 8'd49) begin
            n_fail++;
            $display("FAIL no_increment: time0=%0d, want 49", dut_time(0, 0));
        end
        run(4);
        n_tests++;
        if (dut_time(1, 1) !== 8'd56 || dut_time(1, 0) !== 8'd52) begin
            n_fail++;
            $display("FAIL increment_after: got %0d/%0d, want 52/56", dut_time(1, 0), dut_time(1, 1));
        end
    endtask

    task automatic test_flag;
        logic [7:0] exp_t [3] = '{8'd1, 8'd0, 8'd0};
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run(1);
            n_tests++;
            if (dut_time(2, 0) !== exp_t[i] || go_v[2] !== (i == 2) || zero2[0] !== (i == 2)) begin
                n_fail++;
                $display("FAIL flag_step%0d: time=%0d game_over=%b zero0=%b, want %0d/%0d/%0d",
                         i, dut_time(2, 0), go_v[2], zero2[0], exp_t[i], i == 2, i == 2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            n_tests++;
            if (dut_time(2, 0) !== 8'd0 || dut_time(2, 1) !== 8'd2 || dut_active(2) !== 2'd0 ||
                go_v[2] !== 1'b1 || run_v[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL flag_frozen%0d: t0=%0d t1=%0d active=%0d go=%b run=%b, want 0/2/0/1/0",
                         i, dut_time(2, 0), dut_time(2, 1), dut_active(2), go_v[2], run_v[2]);
            end
        end
        // flag fall and turn_end arriving together
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run(2);
        cycle(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (dut_active(2) !== 2'd0 || go_v[2] !== 1'b1 || zero2 !== 2'b01 || dut_time(2, 1) !== 8'd2) begin
            n_fail++;
            $display("FAIL flag_vs_turn: active=%0d go=%b zero=%b t1=%0d, want 0/1/01/2",
                     dut_active(2), go_v[2], zero2, dut_time(2, 1));
        end
    endtask

    task automatic test_prescaler;
        int exp_t [3] = '{60, 60, 60};
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            run(7);
            cycle(1'b0, 1'b1, 1'b1);
            exp_t[t % 3] -= 2;
            n_tests++;
            if (dut_active(3) !== 2'((t + 1) % 3)) begin
                n_fail++;
                $display("FAIL presc_active%0d: got %0d, want %0d", t, dut_active(3), (t + 1) % 3);
            end
            for (int p = 0; p < 3; p++) begin
                n_tests++;
                if (dut_time(3, p) !== 8'(exp_t[p])) begin
                    n_fail++;
                    $display("FAIL presc_time turn%0d p%0d: got %0d, want %0d", t, p, dut_time(3, p), exp_t[p]);
                end
            end
        end
        // turn ends mid-unit: next mover must wait a full TICK_DIV
        run(2);
        cycle(1'b0, 1'b1, 1'b1);
        run(3);
        n_tests++;
        if (dut_time(3, 1) !== 8'd58 || dut_time(3, 2) !== 8'd58 || dut_active(3) !== 2'd2) begin
            n_fail++;
            $display("FAIL presc_restart: t1=%0d t2=%0d active=%0d, want 58/58/2",
                     dut_time(3, 1), dut_time(3, 2), dut_active(3));
        end
        run(1);
        n_tests++;
        if (dut_time(3, 2) !== 8'd57) begin
            n_fail++;
            $display("FAIL presc_first_unit: t2=%0d, want 57", dut_time(3, 2));
        end
    endtask

    task automatic test_pause;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run(2);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'(i % 2));
            n_tests++;
            if (dut_time(0, 0) !== 8'd57 || dut_active(0) !== 2'd0 || run_v[0] !== 1'b0 ||
                dut_time(3, 0) !== 8'd60 || dut_active(3) !== 2'd0) begin
                n_fail++;
                $display("FAIL pause_hold%0d: d0 t=%0d act=%0d run=%b d3 t=%0d act=%0d, want 57/0/0 60/0",
                         i, dut_time(0, 0), dut_active(0), run_v[0], dut_time(3, 0), dut_active(3));
            end
        end
        run(1);
        n_tests++;
        if (dut_time(0, 0) !== 8'd57 || run_v[0] !== 1'b1 || dut_time(3, 0) !== 8'd60) begin
            n_fail++;
            $display("FAIL pause_resume: d0 t=%0d run=%b d3 t=%0d, want 57/1/60",
                     dut_time(0, 0), run_v[0], dut_time(3, 0));
        end
        run(1);
        n_tests++;
        if (dut_time(0, 0) !== 8'd56 || dut_time(3, 0) !== 8'd59) begin
            n_fail++;
            $display("FAIL pause_continue: d0 t=%0d d3 t=%0d, want 56/59", dut_time(0, 0), dut_time(3, 0));
        end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run(10);
        cycle(1'b0, 1'b1, 1'b1);
        run(43);
        n_tests++;
        if (dut_time(0, 1) !== 8'd17 || run_v[0] !== 1'b1 || go_v[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_setup: d0 t1=%0d run=%b d2 go=%b, want 17/1/1",
                     dut_time(0, 1), run_v[0], go_v[2]);
        end
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k += 2) begin
            n_tests++;
            if (dut_time(k, 0) !== 8'(INIT[k]) || dut_time(k, 1) !== 8'(INIT[k]) ||
                dut_active(k) !== 2'd0 || dut_zero(k, 0) !== 1'b0 || run_v[k] !== 1'b0 || go_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_reset dut%0d: t=%0d/%0d act=%0d z0=%b run=%b go=%b, want %0d/%0d/0/0/0/0",
                         k, dut_time(k, 0), dut_time(k, 1), dut_active(k), dut_zero(k, 0), run_v[k], go_v[k],
                         INIT[k], INIT[k]);
            end
        end
        cycle(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (run_v[0] !== 1'b0 || dut_time(0, 0) !== 8'd60 || dut_active(0) !== 2'd0) begin
            n_fail++;
            $display("FAIL midrun_idle: run=%b t0=%0d act=%0d, want 0/60/0", run_v[0], dut_time(0, 0), dut_active(0));
        end
    endtask

    task automatic test_saturate;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (dut_time(4, 0) !== 8'd255 || dut_active(4) !== 2'd1) begin
            n_fail++;
            $display("FAIL saturate: t0=%0d active=%0d, want 255/1", dut_time(4, 0), dut_active(4));
        end
        run(1);
        n_tests++;
        if (dut_time(4, 1) !== 8'd253 || dut_time(4, 0) !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate_next: t0=%0d t1=%0d, want 255/253", dut_time(4, 0), dut_time(4, 1));
        end
    endtask

    task automatic test_random;
        bit r, s, t;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 9) < 8);
            t = ($urandom_range(0, 3) == 0);
            cycle(r, s, t);
            for (int k = 0; k < NDUT; k++) begin
                n_tests++;
                if (dut_active(k) !== 2'(m_act[k]) || run_v[k] !== (m_mode[k] == 1) ||
                    go_v[k] !== (m_mode[k] == 3)) begin
                    n_fail++;
                    $display("FAIL random_ctrl cyc%0d dut%0d: act=%0d run=%b go=%b, want %0d/%0d/%0d",
                             i, k, dut_active(k), run_v[k], go_v[k], m_act[k], m_mode[k] == 1, m_mode[k] == 3);
                end
                for (int p = 0; p < NP[k]; p++) begin
                    n_tests++;
                    if (dut_time(k, p) !== 8'(m_time[k][p]) || dut_zero(k, p) !== m_zero[k][p]) begin
                        n_fail++;
                        $display("FAIL random_time cyc%0d dut%0d p%0d: t=%0d z=%b, want %0d/%0d",
                                 i, k, p, dut_time(k, p), dut_zero(k, p), m_time[k][p], m_zero[k][p]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_countdown;
        test_increment;
        test_flag;
        test_prescaler;
        test_pause;
        test_reset_mid;
        test_saturate;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
